// File: rtl/pdp1_iot_ctl.sv
// -----------------------------------------------------------------------------
// pdp1_iot_ctl
//
// CPU-side IOT sequencer. Accepts one IOT request from the CPU core,
// broadcasts it on the shared io_* bus for one attention cycle, optionally
// waits for a device completion pulse (bounded by TIMEOUT), then hands the
// resulting IO word back to the CPU. A no-wait IOT that asks for completion
// leaves a pending flag; the next stray device pulse turns into a one-cycle
// sequence-break strobe.
//
// Handshake (CPU side): i_req is a one-cycle strobe and is only honoured
// while the sequencer is idle; it is silently dropped otherwise (no ready
// signal; the CPU watches o_busy). Every accepted request produces exactly
// one o_done pulse unless i_rst intervenes. o_io and o_timeout are valid in
// the o_done cycle and hold until the next accepted request.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_req            one-cycle IOT request strobe
//   i_instr[0:17]    instruction word (bit 0 = MSB); opcode in [0:4]
//   i_io[0:17]       CPU IO register contents
//   i_rd             IOT returns device data into IO
//   o_busy           high while the IOT is being broadcast / awaited
//   o_done           one-cycle completion strobe
//   o_io[0:17]       resulting IO register value
//   o_timeout        wait aborted without a device pulse
//   o_brk            one-cycle deferred-completion (sequence break) strobe
//   io_att           device attention strobe
//   io_op[0:11]      latched instr[6:17]; device code in io_op[6:11]
//   io_sword[0:17]   data to devices (latched i_io)
//   io_pulse         wired-OR device completion pulse
//   io_rword[0:17]   device return data
//   dbg_state        current sequencer state (for checkers / debug)
// -----------------------------------------------------------------------------
module pdp1_iot_ctl #(
  parameter int TIMEOUT = 4096,
  parameter int TW      = 13
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [0:17] i_instr,
  input  logic [0:17] i_io,
  input  logic        i_rd,
  output logic        o_busy,
  output logic        o_done,
  output logic [0:17] o_io,
  output logic        o_timeout,
  output logic        o_brk,
  output logic        io_att,
  output logic [0:11] io_op,
  output logic [0:17] io_sword,
  input  logic        io_pulse,
  input  logic [0:17] io_rword,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ATT  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [0:4]    IOT_OPCODE = 5'b11101;
  localparam logic [TW-1:0] CNT_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] CNT_MAX    = TW'(TIMEOUT);

  state_t       state;
  logic [0:17]  lat_io;
  logic         lat_rd;
  logic         lat_w;
  logic [TW-1:0] cnt;

  // cpend: a no-wait IOT asked for completion and no device pulse has
  // answered it yet. own_cpend marks that the IOT currently in ATT/DONE is
  // the one that raised cpend, so its own broadcast cycles cannot answer it.
  logic         cpend;
  logic         own_cpend;

  logic         accept;
  logic         brk_fire;
  logic         cnt_expired;

  assign accept      = i_req && (state == S_IDLE) && (i_instr[0:4] == IOT_OPCODE);
  assign cnt_expired = (cnt >= CNT_LAST);

  // A pulse during WAIT belongs to the waiting IOT and never answers cpend.
  always_comb begin
    brk_fire = 1'b0;
    if (cpend && io_pulse) begin
      case (state)
        S_IDLE:         brk_fire = 1'b1;
        S_ATT, S_DONE:  brk_fire = !own_cpend;
        default:        brk_fire = 1'b0;
      endcase
    end
  end

  assign dbg_state = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      lat_io    <= '0;
      lat_rd    <= 1'b0;
      lat_w     <= 1'b0;
      cnt       <= '0;
      cpend     <= 1'b0;
      own_cpend <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_io      <= '0;
      o_timeout <= 1'b0;
      o_brk     <= 1'b0;
      io_att    <= 1'b0;
      io_op     <= '0;
      io_sword  <= '0;
    end else begin
      o_brk <= brk_fire;
      if (brk_fire) begin
        cpend <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (accept) begin
            state     <= S_ATT;
            io_att    <= 1'b1;
            o_busy    <= 1'b1;
            io_op     <= i_instr[6:17];
            io_sword  <= i_io;
            lat_io    <= i_io;
            lat_rd    <= i_rd;
            lat_w     <= i_instr[5];
            o_timeout <= 1'b0;
            if (!i_instr[5] && i_instr[6]) begin
              // Overrides the clear above when a break fires this cycle:
              // the new request restarts the pending completion.
              cpend     <= 1'b1;
              own_cpend <= !(cpend && !brk_fire);
            end else begin
              own_cpend <= 1'b0;
            end
          end
        end

        S_ATT: begin
          io_att <= 1'b0;
          if (lat_w) begin
            state <= S_WAIT;
            cnt   <= '0;
          end else begin
            // No-wait IOT: the device word is sampled in the ATT cycle.
            state  <= S_DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            o_io   <= lat_rd ? io_rword : lat_io;
          end
        end

        S_WAIT: begin
          if (io_pulse) begin
            // Pulse beats a simultaneous timeout.
            state  <= S_DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            o_io   <= lat_rd ? io_rword : lat_io;
          end else if (cnt_expired) begin
            state     <= S_DONE;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
            o_io      <= lat_io;
          end else if (cnt < CNT_MAX) begin
            cnt <= cnt + TW'(1);
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          o_done    <= 1'b0;
          own_cpend <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdp1_iot_ctl.sv
// -----------------------------------------------------------------------------
// tb_pdp1_iot_ctl
//
// Directed steps from the test plan followed by randomized IOT transactions.
// Two sequencers share all inputs: the main one (TIMEOUT=16) is checked in
// every step; a TIMEOUT=8 copy is checked only in the timeout step, after a
// reset. Expected values come from transaction-level rules: completion cycle,
// returned word, timeout flag, and a single pending-completion bit.
// -----------------------------------------------------------------------------
module tb_pdp1_iot_ctl;

  localparam int T_MAIN = 16;
  localparam int T_SMALL = 8;

  // clock / reset
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_rst = 1'b1;
  logic        i_req = 1'b0;
  logic [17:0] i_instr = '0;
  logic [17:0] i_io = '0;
  logic        i_rd = 1'b0;
  logic        io_pulse = 1'b0;
  logic [17:0] io_rword = '0;

  logic        a_busy, a_done, a_timeout, a_brk, a_att;
  logic [17:0] a_io, a_sword;
  logic [11:0] a_op;
  logic [1:0]  a_dbg;

  logic        b_busy, b_done, b_timeout, b_brk, b_att;
  logic [17:0] b_io, b_sword;
  logic [11:0] b_op;
  logic [1:0]  b_dbg;

  pdp1_iot_ctl #(.TIMEOUT(T_MAIN), .TW(5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_instr(i_instr),
    .i_io(i_io), .i_rd(i_rd), .o_busy(a_busy), .o_done(a_done),
    .o_io(a_io), .o_timeout(a_timeout), .o_brk(a_brk), .io_att(a_att),
    .io_op(a_op), .io_sword(a_sword), .io_pulse(io_pulse),
    .io_rword(io_rword), .dbg_state(a_dbg)
  );

  pdp1_iot_ctl #(.TIMEOUT(T_SMALL), .TW(4)) dut_t8 (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_instr(i_instr),
    .i_io(i_io), .i_rd(i_rd), .o_busy(b_busy), .o_done(b_done),
    .o_io(b_io), .o_timeout(b_timeout), .o_brk(b_brk), .io_att(b_att),
    .io_op(b_op), .io_sword(b_sword), .io_pulse(io_pulse),
    .io_rword(io_rword), .dbg_state(b_dbg)
  );

  // observed-DUT select
  logic        sel8 = 1'b0;
  logic        m_busy, m_done, m_timeout, m_brk, m_att;
  logic [17:0] m_io, m_sword;
  logic [11:0] m_op;
  assign m_busy    = sel8 ? b_busy    : a_busy;
  assign m_done    = sel8 ? b_done    : a_done;
  assign m_timeout = sel8 ? b_timeout : a_timeout;
  assign m_brk     = sel8 ? b_brk     : a_brk;
  assign m_att     = sel8 ? b_att     : a_att;
  assign m_io      = sel8 ? b_io      : a_io;
  assign m_sword   = sel8 ? b_sword   : a_sword;
  assign m_op      = sel8 ? b_op      : a_op;

  // scoreboard counters
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // per-transaction observations
  int          att_cnt, att_first, busy_cnt, busy_first, busy_last;
  int          done_cnt, done_cyc, brk_cnt, brk_cyc;
  logic [17:0] io_at_done;
  logic        to_at_done, to_cyc1, zero_ok;
  logic [17:0] hist [0:63];

  function automatic logic all_zero();
    return !m_busy && !m_done && (m_io == 18'd0) && !m_timeout && !m_brk &&
           !m_att && (m_op == 12'd0) && (m_sword == 18'd0);
  endfunction

  task automatic drive_cycle(input int c, input int pulse_at, input int pulse_len,
                             input logic [17:0] rword_fix, input logic rand_rword,
                             input int req2_at, input int rst_at);
    i_req    = (c == 0) || (c == req2_at);
    i_rst    = (c == rst_at);
    io_pulse = (pulse_at >= 0) && (c >= pulse_at) && (c < pulse_at + pulse_len);
    io_rword = rand_rword ? 18'($urandom) : rword_fix;
    hist[c]  = io_rword;
  endtask

  // Runs one request starting at cycle 0 (current cycle) through cycle len.
  task automatic run_iot(input logic [17:0] instr, input logic [17:0] io, input logic rd,
                         input int pulse_at, input int pulse_len, input int len,
                         input logic [17:0] rword_fix, input logic rand_rword,
                         input int req2_at, input int rst_at);
    att_cnt = 0; att_first = -1; busy_cnt = 0; busy_first = -1; busy_last = -1;
    done_cnt = 0; done_cyc = -1; brk_cnt = 0; brk_cyc = -1;
    io_at_done = '0; to_at_done = 1'b0; to_cyc1 = 1'bx; zero_ok = 1'b0;
    i_instr = instr; i_io = io; i_rd = rd;
    drive_cycle(0, pulse_at, pulse_len, rword_fix, rand_rword, req2_at, rst_at);
    for (int c = 1; c <= len; c++) begin
      @(posedge i_clk); #1;
      if (m_att)  begin att_cnt++; if (att_first < 0) att_first = c; end
      if (m_busy) begin busy_cnt++; if (busy_first < 0) busy_first = c; busy_last = c; end
      if (m_done) begin done_cnt++; done_cyc = c; io_at_done = m_io; to_at_done = m_timeout; end
      if (m_brk)  begin brk_cnt++; brk_cyc = c; end
      if (c == 1) to_cyc1 = m_timeout;
      if (c == rst_at + 1) zero_ok = all_zero();
      drive_cycle(c, pulse_at, pulse_len, rword_fix, rand_rword, req2_at, rst_at);
    end
    i_req = 1'b0; i_rst = 1'b0; io_pulse = 1'b0;
  endtask

  // One idle-time device pulse; counts o_brk over the following three cycles.
  task automatic idle_pulse(output int n_brk, output logic brk_next);
    n_brk = 0; brk_next = 1'b0;
    io_pulse = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge i_clk); #1;
      io_pulse = 1'b0;
      if (m_brk) begin n_brk++; if (c == 1) brk_next = 1'b1; end
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin @(posedge i_clk); #1; end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_req = 1'b0; io_pulse = 1'b0;
    idle(2);
    i_rst = 1'b0;
  endtask

  // reference-model state
  logic cpend_m = 1'b0;

  initial begin
    int          nb;
    logic        bn;
    logic [17:0] instr, io;
    logic        w, c, rd, iot, pul;
    int          k, exp_done, op;
    logic        exp_to;
    logic [17:0] exp_io;

    // reset state
    i_rst = 1'b1;
    idle(2);
    check("reset_zero", all_zero(), 1'b1);
    i_rst = 1'b0;

    // no-wait IOT
    run_iot(18'o720045, 18'o123456, 1'b0, -1, 0, 4, 18'o555555, 1'b0, -1, -1);
    check("nw_att_first", att_first, 1);
    check("nw_att_cnt", att_cnt, 1);
    check("nw_op", m_op, 12'o0045);
    check("nw_sword", m_sword, 18'o123456);
    check("nw_done_cyc", done_cyc, 2);
    check("nw_io", io_at_done, 18'o123456);
    check("nw_timeout", to_at_done, 1'b0);

    // wait IOT with read, pulse held over cycles 10..11
    run_iot(18'o730045, 18'o111111, 1'b1, 10, 2, 13, 18'o000777, 1'b0, -1, -1);
    check("w_busy_first", busy_first, 1);
    check("w_busy_last", busy_last, 10);
    check("w_done_cyc", done_cyc, 11);
    check("w_done_cnt", done_cnt, 1);
    check("w_io", io_at_done, 18'o000777);
    check("w_brk_cnt", brk_cnt, 0);

    // non-IOT request ignored
    run_iot(18'o200000, 18'o222222, 1'b0, -1, 0, 5, 18'o0, 1'b0, -1, -1);
    check("nio_att", att_cnt, 0);
    check("nio_done", done_cnt, 0);
    check("nio_busy", busy_cnt, 0);

    // second request during WAIT ignored
    run_iot(18'o730045, 18'o333333, 1'b0, 6, 1, 9, 18'o0, 1'b0, 4, -1);
    check("rw_att_cnt", att_cnt, 1);
    check("rw_done_cnt", done_cnt, 1);
    check("rw_done_cyc", done_cyc, 7);
    check("rw_io", io_at_done, 18'o333333);

    // deferred completion: break on the later stray pulse, once
    run_iot(18'o724045, 18'o444444, 1'b0, 9, 1, 12, 18'o0, 1'b0, -1, -1);
    check("dc_done_cyc", done_cyc, 2);
    check("dc_brk_cyc", brk_cyc, 10);
    check("dc_brk_cnt", brk_cnt, 1);
    idle_pulse(nb, bn);
    check("dc_no_second_brk", nb, 0);

    // reset in the middle of a wait IOT
    run_iot(18'o730045, 18'o555555, 1'b0, -1, 0, 10, 18'o0, 1'b0, -1, 5);
    check("rst_zero", zero_ok, 1'b1);
    check("rst_no_done", done_cnt, 0);
    run_iot(18'o720045, 18'o654321, 1'b0, -1, 0, 4, 18'o0, 1'b0, -1, -1);
    check("rst_fresh_done", done_cyc, 2);
    check("rst_fresh_io", io_at_done, 18'o654321);

    // timeout on the TIMEOUT=8 sequencer
    do_reset();
    sel8 = 1'b1;
    run_iot(18'o730045, 18'o765432, 1'b1, -1, 0, 12, 18'o000777, 1'b0, -1, -1);
    check("to_done_cyc", done_cyc, T_SMALL + 2);
    check("to_flag", to_at_done, 1'b1);
    check("to_io", io_at_done, 18'o765432);
    check("to_held", m_timeout, 1'b1);
    run_iot(18'o720045, 18'o000123, 1'b0, -1, 0, 4, 18'o0, 1'b0, -1, -1);
    check("to_cleared", to_cyc1, 1'b0);
    check("to_cleared_done", to_at_done, 1'b0);
    sel8 = 1'b0;
    do_reset();
    cpend_m = 1'b0;

    // randomized transactions on the main sequencer
    for (int t = 0; t < 60; t++) begin
      iot = ($urandom_range(0, 5) != 0);
      w   = 1'($urandom_range(0, 1));
      c   = 1'($urandom_range(0, 1));
      rd  = 1'($urandom_range(0, 1));
      io  = 18'($urandom);
      if (iot) begin
        instr = {5'b11101, w, c, 11'($urandom)};
      end else begin
        op = $urandom_range(0, 30);
        if (op >= 29) op++;
        instr = {5'(op), 13'($urandom)};
      end
      pul = ($urandom_range(0, 3) != 0);
      k   = $urandom_range(2, T_MAIN + 1);
      if (!iot) begin
        run_iot(instr, io, rd, -1, 0, 5, 18'o0, 1'b1, -1, -1);
        check("r_nio_att", att_cnt, 0);
        check("r_nio_done", done_cnt, 0);
      end else begin
        exp_to   = w && !pul;
        exp_done = !w ? 2 : (pul ? k + 1 : T_MAIN + 2);
        run_iot(instr, io, rd, (w && pul) ? k : -1, 1, exp_done + 1, 18'o0, 1'b1, -1, -1);
        exp_io = (rd && !exp_to) ? hist[exp_done - 1] : io;
        check("r_att", {att_cnt[15:0], att_first[15:0]}, {16'd1, 16'd1});
        check("r_op", m_op, instr[11:0]);
        check("r_sword", m_sword, io);
        check("r_to_cyc1", to_cyc1, 1'b0);
        check("r_done_cyc", done_cyc, exp_done);
        check("r_done_cnt", done_cnt, 1);
        check("r_busy_cnt", busy_cnt, exp_done - 1);
        check("r_io", io_at_done, exp_io);
        check("r_timeout", to_at_done, exp_to);
        check("r_brk_none", brk_cnt, 0);
        if (!w && c) cpend_m = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) begin
        idle_pulse(nb, bn);
        check("r_brk_cnt", nb, cpend_m ? 1 : 0);
        check("r_brk_next", bn, cpend_m);
        cpend_m = 1'b0;
      end
      idle($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pdp1_iot_ctl.md
Name: pdp1_iot_ctl

Overview:
- CPU-side IOT sequencer; sits directly upstream of the peripheral devices (line printer etc.) on the shared io_* bus.
- Takes one IOT request from the CPU core, broadcasts it to the devices, and optionally waits for a device completion pulse.
- Returns the device data word, a timeout flag, or a deferred completion (break) indication to the CPU.

Parameters:
- TIMEOUT, 4096, max WAIT-state cycles without io_pulse before abort (>=2).
- TW, 13, width of the timeout counter (must hold TIMEOUT).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_req  in  1  one-cycle IOT request strobe from CPU
- i_instr  in  [0:17]  instruction word (bit 0 MSB)
- i_io  in  [0:17]  CPU IO register contents
- i_rd  in  1  instruction returns device data into IO
- o_busy  out  1  sequencer not IDLE
- o_done  out  1  one-cycle completion strobe to CPU
- o_io  out  [0:17]  resulting IO register value, valid with o_done and held after
- o_timeout  out  1  set with o_done when the wait was aborted; held until next accepted request
- o_brk  out  1  one-cycle deferred-completion (sequence break) strobe
- io_att  out  1  device attention strobe
- io_op  out  [0:11]  = latched instr[6:17]; device code is io_op[6:11]
- io_sword  out  [0:17]  data to devices (= latched i_io)
- io_pulse  in  1  wired-OR device completion pulse
- io_rword  in  [0:17]  device return data

Behaviour:
- Reset (i_rst=1, synchronous): state IDLE; io_att=0, io_op=0, io_sword=0, o_io=0, o_done=0, o_busy=0, o_timeout=0, o_brk=0, counter=0, cpend=0. Applies mid-operation; any in-flight IOT is dropped with no o_done.
- Request acceptance: i_req && state==IDLE && i_instr[0:4]==5'b11101 (opcode 72/73). Latch instr, i_io, i_rd. Clear o_timeout. w = instr[5] (wait), c = instr[6] (completion requested).
- Ignored requests, no response: i_req with non-IOT opcode; i_req while busy.
- States:
  - IDLE -> ATT on accept.
  - ATT: exactly 1 cycle; io_att=1; io_op and io_sword driven from the latches. io_op and io_sword hold their values until the next accept.
    - w=0 -> DONE. If i_rd, io_rword is sampled in this cycle.
    - w=1 -> WAIT; counter=0.
    - io_pulse during ATT is ignored.
  - WAIT: io_att=0; counter increments each cycle.
    - io_pulse=1 -> DONE; sample io_rword if rd.
    - No pulse after TIMEOUT WAIT cycles -> DONE with o_timeout=1; o_io=latched i_io.
    - Pulse and timeout in the same cycle: the pulse wins.
  - DONE: 1 cycle; o_done=1; o_io = sampled io_rword if rd and not timed out, else latched i_io. -> IDLE.
- Latency:
  - No-wait: accept at cycle 0, io_att at 1, o_done at 2.
  - Wait: pulse at cycle k>=2 gives o_done at k+1.
  - Timeout: o_done at TIMEOUT+2.
- Deferred completion:
  - Accept with w=0, c=1 sets cpend at the ATT cycle.
  - While cpend=1 and state is IDLE or ATT/DONE of a different IOT, the first io_pulse produces o_brk=1 for one cycle (next cycle) and clears cpend.
  - A new c=1 no-wait IOT while cpend=1 keeps cpend=1, with no double break.
  - A w=1 IOT consumes the pulse itself; cpend is unchanged by that pulse.
- Counter saturates at TIMEOUT; no wrap.

Test Plan:
- Reset, then i_req with i_instr=0o720045, i_io=0o123456, i_rd=0 -> io_att high at cycle 1 only, io_op=0o0045, io_sword=0o123456; o_done at cycle 2 with o_io=0o123456; o_timeout=0.
- i_instr=0o730045, i_rd=1; bench drives io_pulse at cycles 10–11 with io_rword=0o000777 -> o_busy cycles 1–10, o_done at cycle 11, o_io=0o000777; second pulse cycle ignored, no o_brk.
- TIMEOUT=8, i_instr=0o730045, no pulse -> o_done and o_timeout at cycle 10, o_io=i_io; o_timeout clears on next accept.
- i_instr=0o724045 (w=0,c=1); pulse at cycle 9 -> o_done at 2, o_brk at cycle 10 only; a later pulse produces no o_brk.
- i_req with 0o200000 (non-IOT) and i_req during WAIT -> no io_att, no o_done, state unaffected.
- Assert i_rst at cycle 5 of a wait IOT -> next cycle IDLE, all outputs 0, no o_done; fresh request then completes normally.
